// File: rtl/lmem_nrp_1wp_clr_pkg.sv
// Shared definitions for the multi-read-port local memory with clear sequencer.
// Holds the read-during-write policy codes, the sequencer state type and a sizing helper.
package lmem_nrp_1wp_clr_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } lmemState_t;

   // Number of bits needed to represent values 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/lmem_nrp_1wp_clr_if.sv
// Write/read bus of the local memory: one write port plus NUM_RP packed read ports.
// The kernel side is the master; the memory is the slave.
interface lmem_nrp_1wp_clr_if #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_RP     = 4
);

   logic                         we;
   logic [ADDR_WIDTH-1:0]        waddr;
   logic [DATA_WIDTH-1:0]        wdata;
   logic [NUM_RP-1:0]            re;
   logic [NUM_RP*ADDR_WIDTH-1:0] raddr;
   logic [NUM_RP*DATA_WIDTH-1:0] rdata;
   logic [NUM_RP-1:0]            rvalid;

   modport master (
      output we, waddr, wdata, re, raddr,
      input  rdata, rvalid
   );

   modport slave (
      input  we, waddr, wdata, re, raddr,
      output rdata, rvalid
   );

endinterface

// File: rtl/lmem_nrp_1wp_clr_rd_port.sv
// One read port of the local memory: a private RAM copy fed by the shared write mux,
// an optional same-address bypass, an optional output register and the valid pipeline.
module lmem_nrp_1wp_clr_rd_port
   import lmem_nrp_1wp_clr_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 10,
   parameter int OUT_REG    = 0,
   parameter int RDW_MODE   = RDW_OLD
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rvalid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rvalid;
   logic                  w_bypass;

   // The array itself has no reset so it maps onto block RAM; the clear sweep initialises it.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign w_bypass = (RDW_MODE == RDW_NEW) && i_we && (i_waddr == i_raddr);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= i_re;
         if (i_re) begin
            r_rdata <= w_bypass ? i_wdata : r_mem[i_raddr];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : gOutReg
         logic [DATA_WIDTH-1:0] r_rdataQ;
         logic                  r_rvalidQ;

         // The second stage only reloads on a valid word so the output holds between reads.
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_rdataQ  <= '0;
               r_rvalidQ <= 1'b0;
            end else begin
               r_rvalidQ <= r_rvalid;
               if (r_rvalid) begin
                  r_rdataQ <= r_rdata;
               end
            end
         end

         assign o_rdata  = r_rdataQ;
         assign o_rvalid = r_rvalidQ;
      end else begin : gNoOutReg
         assign o_rdata  = r_rdata;
         assign o_rvalid = r_rvalid;
      end
   endgenerate

endmodule

// File: rtl/lmem_nrp_1wp_clr.sv
// Local memory with one write port, NUM_RP read ports and a clear sequencer that fills
// every word with INIT_WORD after reset or on a clr request.
module lmem_nrp_1wp_clr
   import lmem_nrp_1wp_clr_pkg::*;
#(
   parameter int                    DATA_WIDTH = 18,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    NUM_RP     = 4,
   parameter int                    OUT_REG    = 0,
   parameter int                    RDW_MODE   = RDW_OLD,
   parameter logic [DATA_WIDTH-1:0] INIT_WORD  = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_clr,
   output logic                  o_busy,
   lmem_nrp_1wp_clr_if.slave     io_bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

   lmemState_t            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_busy;

   logic                         w_clearing;
   logic                         w_we;
   logic [ADDR_WIDTH-1:0]        w_waddr;
   logic [DATA_WIDTH-1:0]        w_wdata;
   logic [NUM_RP-1:0]            w_re;
   logic [NUM_RP*DATA_WIDTH-1:0] w_rdata;
   logic [NUM_RP-1:0]            w_rvalid;

   // Sweep sequencer: one INIT_WORD write per cycle, stopping once the last address is written.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            CLEAR: begin
               if (r_cnt == LAST_ADDR) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (i_clr) begin
                  r_cnt   <= '0;
                  r_state <= CLEAR;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= CLEAR;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign w_clearing = (r_state == CLEAR);

   // While clearing, the sweep owns the write port and all reads are suppressed.
   assign w_we    = w_clearing ? 1'b1 : io_bus.we;
   assign w_waddr = w_clearing ? r_cnt[ADDR_WIDTH-1:0] : io_bus.waddr;
   assign w_wdata = w_clearing ? INIT_WORD : io_bus.wdata;
   assign w_re    = w_clearing ? '0 : io_bus.re;

   generate
      for (genvar g = 0; g < NUM_RP; g++) begin : gRdPort
         lmem_nrp_1wp_clr_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .OUT_REG    (OUT_REG),
            .RDW_MODE   (RDW_MODE)
         ) uRdPort (
            .i_clk    (i_clk),
            .i_rstn   (i_rstn),
            .i_we     (w_we),
            .i_waddr  (w_waddr),
            .i_wdata  (w_wdata),
            .i_re     (w_re[g]),
            .i_raddr  (io_bus.raddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .o_rdata  (w_rdata[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_rvalid (w_rvalid[g])
         );
      end
   endgenerate

   assign io_bus.rdata  = w_rdata;
   assign io_bus.rvalid = w_rvalid;

endmodule

// File: doc/lmem_nrp_1wp_clr.md
Name: lmem_nrp_1wp_clr

Overview:
- Parametrised local memory (LMEM) for TyTra kernels: one write port, NUM_RP independent read ports.
- Adds three things to the fixed 4-read-port LMEM:
  - per-port read-enable and valid signalling;
  - a selectable read-during-write policy;
  - a hardware clear sequencer that fills the array with INIT_WORD after reset or on request.
- Sits between kernel datapath pipelines and stream/offset buffers. Inferred as replicated M20K block RAMs (one copy per read port).

Parameters:
- DATA_WIDTH, 18: word width in bits.
- ADDR_WIDTH, 10: address width; DEPTH = 2**ADDR_WIDTH words.
- NUM_RP, 4: number of read ports, 1..8.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- RDW_MODE, 0: same-address read-during-write result. 0 = old data, 1 = new data (bypass).
- INIT_WORD, 0: value written to every location by the clear sweep.

Ports:
- clk, in, 1: single clock, rising edge.
- rstn, in, 1: asynchronous active-low reset.
- clr, in, 1: single-cycle request to re-run the clear sweep.
- busy, out, 1: high while the clear sweep runs.
- we, in, 1: write enable.
- waddr, in, ADDR_WIDTH: write address.
- wdata, in, DATA_WIDTH: write data.
- re, in, NUM_RP: per-port read enable.
- raddr, in, NUM_RP*ADDR_WIDTH: packed read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata, out, NUM_RP*DATA_WIDTH: packed read data, same packing as raddr.
- rvalid, out, NUM_RP: per-port read data valid.

Behaviour:
- Reset (rstn low, asynchronous):
  - rdata = 0, rvalid = 0, busy = 1, sweep counter = 0.
  - FSM forced to CLEAR.
  - Array contents are not reset directly; the sweep overwrites them.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes INIT_WORD to address cnt and increments cnt. When cnt == DEPTH-1 is written, go to IDLE. The sweep takes exactly DEPTH cycles after rstn deasserts.
  - IDLE: busy = 0. clr = 1 sets cnt = 0 and moves to CLEAR; busy rises the next cycle.
- clr while in CLEAR: ignored; the sweep does not restart.
- Reset asserted mid-sweep: sweep restarts from address 0.
- While busy:
  - external we is ignored (no write);
  - re is ignored; rvalid stays 0 and rdata holds its value.
- Write (IDLE, we = 1): mem[waddr] <= wdata at the rising edge.
- Read, port i (IDLE, re[i] = 1):
  - OUT_REG = 0: rdata_i = mem[raddr_i] and rvalid[i] = 1 in cycle T+1.
  - OUT_REG = 1: the same result appears in cycle T+2; the valid is pipelined alongside the data.
- re[i] = 0: rvalid[i] = 0 in the corresponding cycle; rdata_i holds its last value.
- Read-during-write (we with waddr == raddr_i in the same cycle):
  - RDW_MODE = 0: returns pre-write contents.
  - RDW_MODE = 1: returns wdata.
  - Applies independently per port.
- Multiple ports reading the same address: all receive identical data.
- Address wrap: the sweep counter is ADDR_WIDTH+1 bits. Termination is on == DEPTH-1, so there is no aliasing at the wrap.
- Ports are fully independent. There is no back-pressure; the caller honours busy.

Decomposition:
- Package lmem_pkg:
  - constants RDW_OLD = 0, RDW_NEW = 1;
  - FSM state enum {CLEAR, IDLE};
  - function clog2 for counter sizing.
- Sub-module lmem_rd_port, generated NUM_RP times. Each instance contains:
  - its own RAM copy, written by the shared write/clear mux;
  - the RDW bypass compare;
  - the optional output register;
  - the valid pipeline.
- Top level holds the FSM, the sweep counter and the write mux (clear vs. external).

Test Plan:
1. Reset then sweep (ADDR_WIDTH = 4, INIT_WORD = 0x2A): deassert rstn → busy high for exactly 16 cycles. Then read all 16 addresses on port 0 → every word is 0x2A, rvalid pulses 1 cycle after each re.
2. Four-port read (NUM_RP = 4): write 0x11/0x22/0x33/0x44 to addresses 1/2/3/4. Read ports 0..3 at 4/3/2/1 in the same cycle → rdata = 0x44/0x33/0x22/0x11, all rvalid = 1 at T+1. Repeat with OUT_REG = 1 → result at T+2.
3. Read-during-write: address 5 holds 0x0F; write 0x3C to address 5 while port 2 reads address 5. RDW_MODE = 0 → 0x0F; RDW_MODE = 1 → 0x3C. The next read returns 0x3C in both modes.
4. Busy gating: pulse clr in IDLE and assert we (address 7, 0x55) and re[0] during the sweep. Expected:
   - busy high 16 cycles;
   - rvalid stays 0;
   - address 7 reads INIT_WORD after the sweep.
   - clr re-pulsed mid-sweep does not extend busy beyond 16 cycles.
5. Reset mid-sweep: assert rstn low at sweep cycle 9 with rdata nonzero. Expected:
   - rdata and rvalid clear immediately (asynchronous);
   - after release, busy lasts a full 16 cycles again.
